// File: rtl/rate_conv_pkg.sv
// Shared types for the rate converter: config bundle and clamping helper.
// Ratio 0 behaves as 1; phase is pinned inside the group.
package rate_conv_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RATIO_W = 5;
  localparam int DEF_CNT_W   = 32;

  typedef logic [DEF_RATIO_W-1:0] ratio_t;

  typedef struct packed {
    logic   enable;
    ratio_t ratio;
    ratio_t phase;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    enable: 1'b0,
    ratio:  ratio_t'(1),
    phase:  ratio_t'(0)
  };

  function automatic cfg_t clamp_cfg(input cfg_t c);
    cfg_t r;
    r = c;
    if (c.ratio == '0)
      r.ratio = ratio_t'(1);
    if (c.phase >= r.ratio)
      r.phase = r.ratio - ratio_t'(1);
    return r;
  endfunction

endpackage

// File: rtl/rate_conv_skid.sv
// Two-entry stream buffer; ready is simply "not full", so a
// single held entry still allows one push and one pop per cycle.
module rate_conv_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] mem_q [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_q];
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push)
      wr_d = ~wr_q;
    if (pop)
      rd_d = ~rd_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= in_data_i;
  end

endmodule

// File: rtl/rate_conv_decim_core.sv
// Decimating stream stage: keeps one beat per group, always keeps tlast,
// and swaps in a shadow config on frame boundaries.
module rate_conv_decim_core
  import rate_conv_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RATIO_W = DEF_RATIO_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cfg_enable,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic [RATIO_W-1:0] cfg_phase,
  input  logic              cfg_update,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [CNT_W-1:0]  stat_in_cnt,
  output logic [CNT_W-1:0]  stat_out_cnt,
  output logic              stat_cfg_active
);

  cfg_t             act_q, act_d;
  cfg_t             shd_q, shd_d;
  cfg_t             cfg_in;
  logic             pend_q, pend_d;
  ratio_t           ph_q, ph_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic             sk_in_ready;
  logic             sk_out_valid;
  logic [DATA_W:0]  sk_out_data;
  logic             accept, keep, push, pop;

  assign s_axis_tready = sk_in_ready && !areset;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign keep          = !act_q.enable || (ph_q == act_q.phase)
                         || s_axis_tlast;
  assign push          = accept && keep;
  assign m_axis_tvalid = sk_out_valid && !areset;
  assign pop           = m_axis_tvalid && m_axis_tready;

  assign m_axis_tdata    = areset ? '0 : sk_out_data[DATA_W-1:0];
  assign m_axis_tlast    = areset ? 1'b0 : sk_out_data[DATA_W];
  assign stat_in_cnt     = areset ? '0 : in_cnt_q;
  assign stat_out_cnt    = areset ? '0 : out_cnt_q;
  assign stat_cfg_active = pend_q && !areset;

  always_comb begin
    cfg_in        = CFG_RESET;
    cfg_in.enable = cfg_enable;
    cfg_in.ratio  = ratio_t'(cfg_ratio);
    cfg_in.phase  = ratio_t'(cfg_phase);
  end

  always_comb begin
    act_d     = act_q;
    shd_d     = shd_q;
    pend_d    = pend_q;
    ph_d      = ph_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;

    // >= keeps the wrap safe if the ratio shrank under a running count
    if (accept) begin
      in_cnt_d = in_cnt_q + CNT_W'(1);
      if (s_axis_tlast || (ph_q >= act_q.ratio - ratio_t'(1)))
        ph_d = '0;
      else
        ph_d = ph_q + ratio_t'(1);
    end

    if (pop)
      out_cnt_d = out_cnt_q + CNT_W'(1);

    if (pend_q && (!act_q.enable || (accept && s_axis_tlast))) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end

    if (cfg_update) begin
      shd_d  = clamp_cfg(cfg_in);
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      act_q     <= CFG_RESET;
      shd_q     <= CFG_RESET;
      pend_q    <= 1'b0;
      ph_q      <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      act_q     <= act_d;
      shd_q     <= shd_d;
      pend_q    <= pend_d;
      ph_q      <= ph_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  rate_conv_skid #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk         (aclk),
    .srst        (areset),
    .in_data_i   ({s_axis_tlast, s_axis_tdata}),
    .in_valid_i  (push),
    .in_ready_o  (sk_in_ready),
    .out_data_o  (sk_out_data),
    .out_valid_o (sk_out_valid),
    .out_ready_i (m_axis_tready && !areset)
  );

endmodule

// File: tb/tb_rate_conv_decim_core.sv
// Directed bench for the decimator: scoreboard of kept beats,
// occupancy model for input ready, and stall-hold checks.
module tb_rate_conv_decim_core;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [4:0]  cfg_ratio = '0;
  logic [4:0]  cfg_phase = '0;
  logic        cfg_update = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [31:0] in_cnt;
  logic [31:0] out_cnt;
  logic        cfg_active;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [32:0] sb[$];
  int          occ = 0;
  logic        kexp = 1'b0;
  int          in_exp = 0;
  int          out_exp = 0;
  logic        bp_mode = 1'b0;
  logic        rdy = 1'b1;
  int          cyc = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_out = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
  end

  assign m_tready = bp_mode ? cyc[0] : rdy;

  rate_conv_decim_core dut (
    .aclk            (clk),
    .areset          (areset),
    .cfg_enable      (cfg_enable),
    .cfg_ratio       (cfg_ratio),
    .cfg_phase       (cfg_phase),
    .cfg_update      (cfg_update),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .s_axis_tlast    (s_tlast),
    .m_axis_tdata    (m_tdata),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tready   (m_tready),
    .m_axis_tlast    (m_tlast),
    .stat_in_cnt     (in_cnt),
    .stat_out_cnt    (out_cnt),
    .stat_cfg_active (cfg_active)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (areset) begin
      prev_stall = 1'b0;
      occ = 0;
    end else begin
      check("s_tready_occ", s_tready, occ < 2);
      if (prev_stall) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_hold", {m_tlast, m_tdata}, prev_out);
      end
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0)
          check("sb_underflow", sb.size(), 1);
        else
          check("out_beat", {m_tlast, m_tdata}, sb.pop_front());
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out = {m_tlast, m_tdata};
      occ = occ + ((s_tvalid && s_tready && kexp) ? 1 : 0)
                - ((m_tvalid && m_tready) ? 1 : 0);
    end
  end

  task automatic beat(input logic [31:0] d, input logic l, input logic k,
                      output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    s_tdata = d;
    s_tlast = l;
    s_tvalid = 1'b1;
    kexp = k;
    if (k) sb.push_back({l, d});
    while (!acc) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      if (!acc) begin
        waits++;
        if (waits > 200) begin
          check("accept_timeout", waits, 0);
          break;
        end
      end
    end
    if (acc) begin
      in_exp++;
      if (k) out_exp++;
    end
    s_tvalid = 1'b0;
    kexp = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic k);
    int w;
    beat(d, l, k, w);
  endtask

  task automatic update(input logic en, input logic [4:0] r,
                        input logic [4:0] p);
    cfg_enable = en;
    cfg_ratio = r;
    cfg_phase = p;
    cfg_update = 1'b1;
    @(posedge clk);
    #1;
    cfg_update = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic counters(input string tag);
    @(negedge clk);
    check({tag, "_in_cnt"}, in_cnt, in_exp);
    check({tag, "_out_cnt"}, out_cnt, out_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic active_is(input string tag, input logic v);
    @(negedge clk);
    check(tag, cfg_active, v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_in_cnt", in_cnt, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_cfg_active", cfg_active, 0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    check("tready_after_rst", s_tready, 1);
    @(posedge clk);
    #1;

    for (int i = 1; i <= 8; i++)
      send(32'(i), i == 8, 1'b1);
    drain();
    counters("bypass");

    update(1'b1, 5'd4, 5'd0);
    active_is("pend_set", 1'b1);
    active_is("pend_bypass_apply", 1'b0);
    for (int i = 0; i < 16; i++) begin
      beat(32'(i), 1'b0, (i % 4) == 0, w);
      check("tready_high", w, 0);
    end
    drain();
    counters("decim4");

    update(1'b1, 5'd5, 5'd2);
    send(32'h99, 1'b1, 1'b1);
    active_is("pend_r5_clear", 1'b0);
    for (int i = 0; i < 7; i++)
      send(32'hA0 + 32'(i), i == 6, (i == 2) || (i == 6));
    for (int i = 0; i < 4; i++)
      send(32'hB0 + 32'(i), i == 3, (i == 2) || (i == 3));
    drain();
    counters("phase");

    update(1'b1, 5'd2, 5'd0);
    send(32'hC9, 1'b1, 1'b1);
    send(32'hC0, 1'b0, 1'b1);
    send(32'hC1, 1'b0, 1'b0);
    update(1'b1, 5'd3, 5'd0);
    active_is("defer_pend", 1'b1);
    send(32'hC2, 1'b0, 1'b1);
    send(32'hC3, 1'b0, 1'b0);
    send(32'hC4, 1'b0, 1'b1);
    active_is("defer_still_pend", 1'b1);
    send(32'hC5, 1'b1, 1'b1);
    active_is("defer_applied", 1'b0);
    for (int i = 0; i < 7; i++)
      send(32'hD0 + 32'(i), i == 6, ((i % 3) == 0) || (i == 6));
    drain();
    counters("defer");

    update(1'b1, 5'd1, 5'd0);
    send(32'hE0, 1'b1, 1'b1);
    bp_mode = 1'b1;
    for (int i = 0; i < 100; i++)
      send(32'h100 + 32'(i), i == 99, 1'b1);
    drain();
    bp_mode = 1'b0;
    counters("backpressure");

    update(1'b1, 5'd3, 5'd7);
    send(32'h77, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      send(32'h60 + 32'(i), i == 5, (i == 2) || (i == 5));
    update(1'b1, 5'd0, 5'd3);
    send(32'h78, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      send(32'h70 + 32'(i), i == 2, 1'b1);
    drain();
    counters("clamp");

    update(1'b1, 5'd2, 5'd1);
    active_is("pre_rst_pend", 1'b1);
    for (int i = 0; i < 3; i++)
      send(32'hF0 + 32'(i), 1'b0, 1'b1);
    areset = 1'b1;
    sb.delete();
    in_exp = 0;
    out_exp = 0;
    @(negedge clk);
    check("mid_rst_s_tready", s_tready, 0);
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_m_tdata", m_tdata, 0);
    check("mid_rst_m_tlast", m_tlast, 0);
    check("mid_rst_in_cnt", in_cnt, 0);
    check("mid_rst_out_cnt", out_cnt, 0);
    check("mid_rst_cfg_active", cfg_active, 0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    check("post_rst_m_tvalid", m_tvalid, 0);
    check("post_rst_cfg_active", cfg_active, 0);
    @(posedge clk);
    #1;
    counters("post_rst");
    for (int i = 3; i < 6; i++)
      send(32'hF0 + 32'(i), i == 5, 1'b1);
    for (int i = 0; i < 4; i++)
      send(32'h50 + 32'(i), i == 3, 1'b1);
    drain();
    counters("rst_bypass");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
